sopc_video_cpu_oci_dct_packer: RTL and testbench

Data-trace packer for the SOPC_Video CPU on-chip instrumentation path: the producer side of the 30-bit `dct_buffer` / 4-bit `dct_count` trace interface consumed by the OCI test-bench monitor. It packs 2-bit branch-trace codes into a 15-slot shift buffer and hands completed or flushed frames to the trace FIFO through a single-entry valid/ready output register. On an end-of-test request it drains residual codes, then raises `test_ending` / `test_has_ended` for the monitor.

---
 rtl/sopc_video_cpu_oci_dct_packer.sv | 119 +++++++++++
 tb/tb_sopc_video_cpu_oci_dct_packer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sopc_video_cpu_oci_dct_packer.sv
// Packs 2-bit branch-trace codes into 15-slot frames and drains them on end-of-test.
// Latency: a completed or flushed frame appears on out_valid one cycle after its last code or flush.
// Backpressure: single-entry output register; a full buffer waits for it, and extra codes are dropped (sticky overflow).
module sopc_video_cpu_oci_dct_packer #(
    parameter int CODE_W = 2,
    parameter int SLOTS  = 15
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       code_valid,
    input  logic [CODE_W-1:0]          code,
    input  logic                       flush,
    input  logic                       test_end_req,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [CODE_W*SLOTS-1:0]    out_data,
    output logic [$clog2(SLOTS+1)-1:0] out_count,
    output logic [CODE_W*SLOTS-1:0]    dct_buffer,
    output logic [$clog2(SLOTS+1)-1:0] dct_count,
    output logic                       overflow,
    output logic                       test_ending,
    output logic                       test_has_ended
);

    localparam int BW = CODE_W * SLOTS;
    localparam int CW = $clog2(SLOTS + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(SLOTS);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ENDED = 2'd2
    } state_t;

    state_t state;
    logic   pend_flush;

    logic          out_free;
    logic          run;
    logic          accept;
    logic          drop;
    logic [BW-1:0] next_buf;
    logic [CW-1:0] next_cnt;
    logic          want_flush;
    logic          emit;
    logic          next_pend;

    // Append the incoming code first, then decide whether the result leaves as a frame this edge
    always_comb begin
        out_free   = !out_valid || out_ready;
        run        = (state == ST_RUN);
        accept     = run && code_valid && (dct_count != FULL_CNT);
        drop       = run && code_valid && (dct_count == FULL_CNT);
        next_buf   = dct_buffer;
        next_cnt   = dct_count;
        if (accept) begin
            next_buf = {dct_buffer[BW-CODE_W-1:0], code};
            next_cnt = dct_count + CW'(1);
        end
        // End-of-test carries an implicit flush so residual codes get drained
        want_flush = pend_flush || (run && (flush || test_end_req));
        emit       = out_free && ((next_cnt == FULL_CNT) ||
                                  (want_flush && (next_cnt != '0)));
        // A flush of an empty buffer evaporates; otherwise it waits for the output
        next_pend  = !emit && want_flush && (next_cnt != '0);
    end

    // Packing buffer, output register, sticky flags and the run/drain/ended sequence
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ST_RUN;
            pend_flush     <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_count      <= '0;
            dct_buffer     <= '0;
            dct_count      <= '0;
            overflow       <= 1'b0;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            pend_flush <= next_pend;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (emit) begin
                out_valid  <= 1'b1;
                out_data   <= next_buf;
                out_count  <= next_cnt;
                dct_buffer <= '0;
                dct_count  <= '0;
            end else begin
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
                dct_buffer <= next_buf;
                dct_count  <= next_cnt;
            end
            case (state)
                ST_RUN: begin
                    if (test_end_req) begin
                        state       <= ST_DRAIN;
                        test_ending <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if ((dct_count == '0) && !out_valid && !pend_flush) begin
                        state          <= ST_ENDED;
                        test_has_ended <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_ENDED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sopc_video_cpu_oci_dct_packer.sv
// Directed bench for the trace packer: vector table for basic packing/flush, hand sequences for the rest.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Output backpressure is exercised by holding out_ready low in the hand sequences.
module tb_sopc_video_cpu_oci_dct_packer;

    logic        clk;
    logic        reset_n;
    logic        code_valid;
    logic [1:0]  code;
    logic        flush;
    logic        test_end_req;
    logic        out_ready;
    logic        out_valid;
    logic [29:0] out_data;
    logic [3:0]  out_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic        test_ending;
    logic        test_has_ended;

    int total;
    int bad;

    sopc_video_cpu_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .code_valid     (code_valid),
        .code           (code),
        .flush          (flush),
        .test_end_req   (test_end_req),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_count      (out_count),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .overflow       (overflow),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic [1:0]  cd;
        logic        fl;
        logic        rdy;
        logic        ov;
        logic [29:0] od;
        logic [3:0]  oc;
        logic [3:0]  dc;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic cv, input logic [1:0] cd, input logic fl,
                                input logic rdy, input logic ov, input logic [29:0] od,
                                input logic [3:0] oc, input logic [3:0] dc);
        vec_t v;
        v.cv  = cv;
        v.cd  = cd;
        v.fl  = fl;
        v.rdy = rdy;
        v.ov  = ov;
        v.od  = od;
        v.oc  = oc;
        v.dc  = dc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        code_valid   = 1'b0;
        code         = 2'd0;
        flush        = 1'b0;
        test_end_req = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        out_ready = 1'b1;
        reset_n   = 1'b0;
        step();
        reset_n   = 1'b1;
    endtask

    task automatic push(input logic [1:0] c);
        code_valid = 1'b1;
        code       = c;
        step();
        code_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        out_ready = 1'b1;
        idle_inputs();

        // Table: 15 codes 0,1,2,3,... then 3 codes, flush, empty flush
        for (int i = 0; i < 15; i++) begin
            vecs[i] = mk(1'b1, 2'(i % 4), 1'b0, 1'b1, (i == 14),
                         (i == 14) ? 30'h06C6C6C6 : 30'h0,
                         (i == 14) ? 4'd15 : 4'd0,
                         (i == 14) ? 4'd0 : 4'(i + 1));
        end
        vecs[15] = mk(1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0, 4'd1);
        vecs[16] = mk(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0, 4'd2);
        vecs[17] = mk(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0, 4'd3);
        vecs[18] = mk(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 30'h39, 4'd3, 4'd0);
        vecs[19] = mk(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 30'h0,  4'd0, 4'd0);
        vecs[20] = mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0, 4'd0);

        // Reset state
        step();
        reset_n = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dct_count", 32'(dct_count), 32'd0);
        chk("rst_dct_buffer", 32'(dct_buffer), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_test_ending", 32'(test_ending), 32'd0);
        chk("rst_test_has_ended", 32'(test_has_ended), 32'd0);

        for (int i = 0; i < 21; i++) begin
            code_valid = vecs[i].cv;
            code       = vecs[i].cd;
            flush      = vecs[i].fl;
            out_ready  = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            chk($sformatf("vec%0d_dct_count", i), 32'(dct_count), 32'(vecs[i].dc));
            if (vecs[i].ov) begin
                chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].od));
                chk($sformatf("vec%0d_out_count", i), 32'(out_count), 32'(vecs[i].oc));
            end
        end
        idle_inputs();

        // Backpressure: first frame held, second buffer fills, two codes dropped
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) push(2'd1);
        chk("bp_first_valid", 32'(out_valid), 32'd1);
        chk("bp_first_data", 32'(out_data), 32'h15555555);
        for (int i = 0; i < 15; i++) push(2'd2);
        chk("bp_fill_count", 32'(dct_count), 32'd15);
        chk("bp_no_overflow_yet", 32'(overflow), 32'd0);
        chk("bp_hold_data", 32'(out_data), 32'h15555555);
        push(2'd3);
        push(2'd3);
        chk("bp_overflow", 32'(overflow), 32'd1);
        chk("bp_count_kept", 32'(dct_count), 32'd15);
        out_ready = 1'b1;
        step();
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        chk("bp_second_data", 32'(out_data), 32'h2AAAAAAA);
        chk("bp_second_count", 32'(out_count), 32'd15);
        chk("bp_buffer_cleared", 32'(dct_count), 32'd0);
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_overflow_sticky", 32'(overflow), 32'd1);

        // Flush together with a code: the code is included in the frame
        do_reset();
        for (int i = 0; i < 4; i++) push(2'd3);
        code_valid = 1'b1;
        code       = 2'd2;
        flush      = 1'b1;
        step();
        idle_inputs();
        chk("fc_valid", 32'(out_valid), 32'd1);
        chk("fc_count", 32'(out_count), 32'd5);
        chk("fc_data", 32'(out_data), 32'h3FE);

        // End of test: residual frame drained, codes during drain ignored
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) push(2'd1);
        test_end_req = 1'b1;
        step();
        test_end_req = 1'b0;
        chk("te_ending", 32'(test_ending), 32'd1);
        chk("te_frame_valid", 32'(out_valid), 32'd1);
        chk("te_frame_count", 32'(out_count), 32'd7);
        chk("te_frame_data", 32'(out_data), 32'h1555);
        for (int i = 0; i < 4; i++) push(2'd3);
        chk("te_codes_ignored", 32'(dct_count), 32'd0);
        chk("te_no_overflow", 32'(overflow), 32'd0);
        chk("te_not_ended_yet", 32'(test_has_ended), 32'd0);
        chk("te_frame_held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        chk("te_transferred", 32'(out_valid), 32'd0);
        chk("te_ended_wait", 32'(test_has_ended), 32'd0);
        step();
        chk("te_has_ended", 32'(test_has_ended), 32'd1);
        push(2'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("te_ended_flush_ignored", 32'(out_valid), 32'd0);
        chk("te_ended_sticky", 32'(test_has_ended), 32'd1);

        // Reset mid-frame discards everything
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) push(2'd1);
        for (int i = 0; i < 9; i++) push(2'd2);
        chk("mr_pre_count", 32'(dct_count), 32'd9);
        chk("mr_pre_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        step();
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_count", 32'(dct_count), 32'd0);
        chk("mr_buffer", 32'(dct_buffer), 32'd0);
        chk("mr_out_data", 32'(out_data), 32'd0);
        chk("mr_out_count", 32'(out_count), 32'd0);
        reset_n = 1'b1;
        step();
        chk("mr_no_emit", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
